// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {IDLE, SHIFT} bcd_state_t;

  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

  // Smallest digit count d with 10**d > 2**width-1.
  function automatic int bcd_digits_for(int width);
    longint max_v;
    longint p;
    int     d;
    max_v = (longint'(1) << width) - 1;
    p     = 10;
    d     = 1;
    for (int i = 0; i < 20; i++) begin
      if (p <= max_v) begin
        p = p * 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a digit of 5..9 gets +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'(BCD_ADJ_THRESH)) ? d_i + 4'(BCD_ADJ_ADD) : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Result, sign and leading-zero blanks are registered and updated together on done.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic [DIGITS-1:0]     blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [DIGITS-1:0] BLANK_ZERO = {DIGITS{1'b1}} << 1;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("bin_to_bcd_seq: WIDTH must be in 2..32");
  end
  if (DIGITS < bcd_digits_for(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  bcd_state_t          state_q;
  logic [CW-1:0]       cnt_q;
  logic [BW-1:0]       acc_q;
  logic [WIDTH-1:0]    bin_q;
  logic                sign_q;
  logic                busy_q;
  logic                done_q;
  logic [BW-1:0]       bcd_q;
  logic                neg_q;
  logic [DIGITS-1:0]   blank_q;

  logic [WIDTH-1:0]    mag;
  logic                sign_d;
  logic [BW-1:0]       acc_adj;
  logic [BW+WIDTH-1:0] sh_d;
  logic [BW-1:0]       acc_d;
  logic [WIDTH-1:0]    bin_d;
  logic [DIGITS-1:0]   blank_d;
  logic                any_nz;

  // Two's-complement negate; the most negative value wraps to its unsigned magnitude.
  assign sign_d = (SIGNED != 0) && bin_in[WIDTH-1];
  assign mag    = sign_d ? -bin_in : bin_in;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_add3 u_add3 (
      .d_i (acc_q[4*k +: 4]),
      .d_o (acc_adj[4*k +: 4])
    );
  end

  assign sh_d  = {acc_adj, bin_q} << 1;
  assign acc_d = sh_d[BW+WIDTH-1:WIDTH];
  assign bin_d = sh_d[WIDTH-1:0];

  always_comb begin
    blank_d = '0;
    any_nz  = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      any_nz     = any_nz | (acc_d[4*k +: 4] != 4'd0);
      blank_d[k] = ~any_nz;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      blank_q <= BLANK_ZERO;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            bin_q   <= mag;
            sign_q  <= sign_d;
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          bin_q <= bin_d;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            bcd_q   <= acc_d;
            neg_q   <= sign_q;
            blank_q <= blank_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg     = neg_q;
  assign blank   = blank_q;

endmodule
